reg_file_mp: RTL and testbench
==============================

# reg_file_mp

Parametrised multi-port integer register file for the Kasumi core. It adds clocked writes, asynchronous reset, configurable read/write port counts, and a per-register busy scoreboard for hazard detection. It sits between decode (read ports, issue) and writeback (write ports). It replaces the single-write, two-read combinational register file in multi-issue and pipelined configurations.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, architectural register count; must be a power of two, ≥ 2
- AW, $clog2(NREGS), address width; derived, not overridden
- NRD, 2, read port count, 1..4
- NWR, 1, write port count, 1..2
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_addr  in  NRD*AW  read addresses; port i is bits [i*AW +: AW]
- rd_data  out  NRD*XLEN  read data; port i is bits [i*XLEN +: XLEN]
- rd_hazard  out  NRD  port i is reading a busy register
- wr_en  in  NWR  write strobes
- wr_addr  in  NWR*AW  write addresses
- wr_data  in  NWR*XLEN  write data; a write also clears the register's busy bit
- iss_valid  in  1  instruction issued that will write iss_addr
- iss_addr  in  AW  destination of the issued instruction
- iss_stall  out  1  iss_addr is busy and not being written back this cycle (WAW)

## Operation
- Register 0 is hardwired to zero.
  - Writes to it are dropped.
  - It never sets busy.
  - Reads of it return 0, and rd_hazard for it is always 0.
- Writes are synchronous. When wr_en[k] is set and wr_addr[k] != 0, the register takes wr_data[k] at the edge.
- Both write ports targeting the same address in one cycle: port NWR-1 (the highest index) wins the data. The busy bit is cleared once.
- Reads are combinational from the array, subject to the bypass described under Configuration.
- Scoreboard: one busy bit per register.
  - Set: iss_valid & iss_addr != 0 & !iss_stall.
  - Clear: any wr_en to that address.
  - Set and clear on the same register in the same cycle: set wins, so the bit stays 1 because the new writer is pending.
- rd_hazard[i] = busy[rd_addr[i]] & ~(a write to rd_addr[i] this cycle & bypass enabled).
- iss_stall = iss_valid & busy[iss_addr] & no write to iss_addr this cycle. When iss_stall is 1 the issue is ignored by the scoreboard; the upstream stage must hold.
- A write to a register that is not busy is legal, updates data, and leaves busy at 0.

## Timing
- Reset (rst_n low, asynchronous): all registers and all busy bits go to 0 immediately.
  - rd_data reads 0 for every address.
  - rd_hazard = 0 and iss_stall = 0.
- Reset asserted mid-operation discards any pending scoreboard state. No write completes in a cycle where rst_n is low.
- Read latency is 0 cycles, combinational.
- Write latency is 1 cycle: without bypass, data written at edge N is readable after edge N.
- Busy bits update at the edge. The rd_hazard and iss_stall paths from busy are combinational.

## Configuration
- REG_FILE_BYPASS_EN defined:
  - A read whose address matches an active write in the same cycle returns that write data (highest write index wins).
  - The matching rd_hazard is suppressed.
- REG_FILE_BYPASS_EN undefined:
  - Reads return the pre-edge array value.
  - rd_hazard stays asserted until the cycle after the writeback edge.
- Register 0 is never bypassed in either configuration.

## Structure
- Package reg_file_pkg holds:
  - default XLEN and NREGS localparams
  - the ZERO_REG = 0 constant
  - a reg_addr_t typedef sized from the default NREGS
- Sub-module reg_scoreboard (ports: clk, rst_n, iss/clear vectors, busy[NREGS-1:0]) owns the busy bits and the set-wins rule.
- reg_file_mp owns the data array, write-port priority, bypass muxing and hazard/stall combination.

## Test plan
- Reset, then read all 32 addresses: every rd_data = 0, every rd_hazard = 0. Assert rst_n low mid-run after writing x5 = 0xDEADBEEF: x5 reads 0 immediately.
- Write x0 = 0xFFFFFFFF, and issue with iss_addr = 0: x0 reads 0, no busy bit set, iss_stall = 0.
- Issue x7, then read x7 on port 1: rd_hazard[1] = 1 for 3 cycles.
  - Writeback x7 = 0x12345678: with REG_FILE_BYPASS_EN, same-cycle rd_data = 0x12345678 and hazard = 0.
  - Without the macro: old value that cycle, new value and hazard = 0 the next cycle.
- NWR = 2, both ports write x3 (0xAAAA0000 on port 0, 0x5555FFFF on port 1): x3 = 0x5555FFFF next cycle.
- Issue x9, then issue x9 again: second issue gives iss_stall = 1 and busy is unchanged. Re-issue x9 in the same cycle as writeback of x9: iss_stall = 0 and x9 remains busy afterwards.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the Kasumi multi-port integer register file.
package reg_file_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int ZERO_REG  = 0;

  typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;

endpackage : reg_file_pkg

// File: rtl/reg_file_scoreboard.sv
// Busy-bit scoreboard: one pending-writer flag per register; a new issue
// outranks a same-cycle writeback so the bit stays set for the new writer.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NREGS = NREGS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREGS-1:0] iss_set_i,
  input  logic [NREGS-1:0] clr_i,
  output logic [NREGS-1:0] busy_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  always_comb begin
    busy_d           = (busy_q & ~clr_i) | iss_set_i;
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule : reg_scoreboard

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with busy scoreboard and hazard/stall
// outputs. Define REG_FILE_BYPASS_EN to forward same-cycle write data to reads.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS),
  parameter int NRD   = 2,
  parameter int NWR   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_hazard,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_addr,
  output logic                iss_stall
);

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] wr_hit;
  logic [XLEN-1:0]  wr_val [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] iss_set;

  // Per-register write decode; later ports overwrite earlier ones so the
  // highest-index port wins on an address collision.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    logic [AW-1:0] wa;
    wa     = '0;
    wr_hit = '0;
    for (int r = 0; r < NREGS; r++) begin
      wr_val[r] = '0;
    end
    for (int k = 0; k < NWR; k++) begin
      wa = wr_addr[k*AW +: AW];
      if (wr_en[k] && (wa != AW'(ZERO_REG))) begin
        wr_hit[wa] = 1'b1;
        wr_val[wa] = wr_data[k*XLEN +: XLEN];
      end
    end
  end

  // NOTE: the array is reset because an architectural reset must make every
  // register read zero immediately; this costs a reset net per flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments for all sequential state.
      for (int r = 0; r < NREGS; r++) begin
        if (wr_hit[r]) begin
          regs_q[r] <= wr_val[r];
        end
      end
    end
  end

  // WAW: a busy destination may only be re-issued in the cycle its
  // writeback lands.
  assign iss_stall = iss_valid & busy[iss_addr] & ~wr_hit[iss_addr];

  always_comb begin
    iss_set = '0;
    if (iss_valid && !iss_stall && (iss_addr != AW'(ZERO_REG))) begin
      iss_set[iss_addr] = 1'b1;
    end
  end

  reg_scoreboard #(
    .NREGS(NREGS)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .iss_set_i(iss_set),
    .clr_i    (wr_hit),
    .busy_o   (busy)
  );

  always_comb begin
    logic [AW-1:0] ra;
    ra        = '0;
    rd_data   = '0;
    rd_hazard = '0;
    for (int i = 0; i < NRD; i++) begin
      ra = rd_addr[i*AW +: AW];
      if (ra == AW'(ZERO_REG)) begin
        rd_data[i*XLEN +: XLEN] = '0;
        rd_hazard[i]            = 1'b0;
      end else if (BYPASS && wr_hit[ra]) begin
        rd_data[i*XLEN +: XLEN] = wr_val[ra];
        rd_hazard[i]            = 1'b0;
      end else begin
        rd_data[i*XLEN +: XLEN] = regs_q[ra];
        rd_hazard[i]            = busy[ra];
      end
    end
  end

endmodule : reg_file_mp

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed scenarios plus randomized
// traffic against an array-based reference model.
module tb_reg_file_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int NWR   = 2;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                clk;
  logic                rst_n;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_hazard;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_valid;
  logic [AW-1:0]       iss_addr;
  logic                iss_stall;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_regs [NREGS];
  bit          m_busy [NREGS];

  reg_file_mp #(
    .XLEN (XLEN),
    .NREGS(NREGS),
    .NRD  (NRD),
    .NWR  (NWR)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_hazard(rd_hazard),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_valid(iss_valid),
    .iss_addr (iss_addr),
    .iss_stall(iss_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model_reset();
    for (int r = 0; r < NREGS; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
  endfunction

  function automatic bit written_now(input int a);
    bit hit = 1'b0;
    for (int k = 0; k < NWR; k++)
      if (wr_en[k] && int'(wr_addr[k*AW +: AW]) == a && a != 0) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic [31:0] written_val(input int a);
    logic [31:0] v = '0;
    for (int k = 0; k < NWR; k++)
      if (wr_en[k] && int'(wr_addr[k*AW +: AW]) == a) v = wr_data[k*XLEN +: XLEN];
    return v;
  endfunction

  function automatic logic [31:0] exp_read(input int a);
    if (a == 0) return '0;
    if (BYPASS && written_now(a)) return written_val(a);
    return m_regs[a];
  endfunction

  function automatic bit exp_hazard(input int a);
    return (a != 0) && m_busy[a] && !(BYPASS && written_now(a));
  endfunction

  function automatic bit exp_stall();
    return iss_valid && m_busy[int'(iss_addr)] && !written_now(int'(iss_addr));
  endfunction

  function automatic void model_update();
    bit stall = exp_stall();
    for (int k = 0; k < NWR; k++) begin
      int a = int'(wr_addr[k*AW +: AW]);
      if (wr_en[k] && a != 0) begin
        m_regs[a] = wr_data[k*XLEN +: XLEN];
        m_busy[a] = 1'b0;
      end
    end
    if (iss_valid && iss_addr != 0 && !stall) m_busy[int'(iss_addr)] = 1'b1;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_idle();
    wr_en     = '0;
    wr_addr   = '0;
    wr_data   = '0;
    iss_valid = 1'b0;
    iss_addr  = '0;
  endtask

  task automatic set_rd(input int i, input int a);
    logic [AW-1:0] av = AW'(a);
    rd_addr[i*AW +: AW] = av;
  endtask

  task automatic set_wr(input int k, input int a, input logic [31:0] d);
    logic [AW-1:0] av = AW'(a);
    wr_en[k]               = 1'b1;
    wr_addr[k*AW +: AW]    = av;
    wr_data[k*XLEN +: XLEN] = d;
  endtask

  task automatic set_iss(input int a);
    iss_valid = 1'b1;
    iss_addr  = AW'(a);
  endtask

  task automatic check_outputs();
    for (int i = 0; i < NRD; i++) begin
      int a = int'(rd_addr[i*AW +: AW]);
      check($sformatf("rd_data[%0d] x%0d", i, a), rd_data[i*XLEN +: XLEN], exp_read(a));
      check($sformatf("rd_hazard[%0d] x%0d", i, a), 32'(rd_hazard[i]), 32'(exp_hazard(a)));
    end
    check("iss_stall", 32'(iss_stall), 32'(exp_stall()));
  endtask

  task automatic sample();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic commit();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n   = 1'b0;
    rd_addr = '0;
    set_idle();
    model_reset();
    #12 rst_n = 1'b1;

    // All registers read zero and hazard-free after reset.
    for (int a = 0; a < 16; a++) begin
      set_rd(0, a);
      set_rd(1, a + 16);
      #1;
      check($sformatf("post-reset rd0 x%0d", a), rd_data[31:0], 32'h0);
      check($sformatf("post-reset rd1 x%0d", a + 16), rd_data[63:32], 32'h0);
      check($sformatf("post-reset haz x%0d/x%0d", a, a + 16), 32'(rd_hazard), 32'h0);
    end
    @(posedge clk); #1;

    // Write x5, then an asynchronous reset clears it immediately.
    set_idle(); set_rd(0, 5); set_rd(1, 0);
    set_wr(0, 5, 32'hDEADBEEF);
    sample(); commit();
    set_idle();
    #1;
    check("x5 written", rd_data[31:0], 32'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("x5 after async reset", rd_data[31:0], 32'h0);
    check("stall in reset", 32'(iss_stall), 32'h0);
    #1 rst_n = 1'b1;
    sample(); commit();

    // x0 write and issue are both dropped.
    set_wr(0, 0, 32'hFFFFFFFF); set_iss(0); set_rd(0, 0); set_rd(1, 0);
    sample();
    check("issue x0 stall", 32'(iss_stall), 32'h0);
    commit();
    set_idle(); set_iss(0);
    sample();
    check("x0 reads zero", rd_data[31:0], 32'h0);
    check("x0 no hazard", 32'(rd_hazard), 32'h0);
    check("x0 never busy", 32'(iss_stall), 32'h0);
    commit();

    // Issue x7, observe hazard for 3 cycles, then writeback.
    set_idle(); set_iss(7);
    sample(); commit();
    set_idle(); set_rd(1, 7);
    for (int c = 0; c < 3; c++) begin
      sample();
      check($sformatf("x7 hazard cycle %0d", c), 32'(rd_hazard[1]), 32'h1);
      commit();
    end
    set_wr(0, 7, 32'h12345678);
    sample();
    check("x7 wb-cycle data", rd_data[63:32], BYPASS ? 32'h12345678 : 32'h0);
    check("x7 wb-cycle hazard", 32'(rd_hazard[1]), BYPASS ? 32'h0 : 32'h1);
    commit();
    set_idle();
    sample();
    check("x7 after wb data", rd_data[63:32], 32'h12345678);
    check("x7 after wb hazard", 32'(rd_hazard[1]), 32'h0);
    commit();

    // Both write ports hit x3: port 1 wins.
    set_wr(0, 3, 32'hAAAA0000); set_wr(1, 3, 32'h5555FFFF); set_rd(0, 3);
    sample(); commit();
    set_idle();
    sample();
    check("x3 dual write", rd_data[31:0], 32'h5555FFFF);
    commit();

    // WAW stall on x9, then re-issue coinciding with writeback.
    set_iss(9); set_rd(0, 9);
    sample(); commit();
    set_iss(9);
    sample();
    check("x9 reissue stall", 32'(iss_stall), 32'h1);
    commit();
    set_idle();
    sample();
    check("x9 still busy", 32'(rd_hazard[0]), 32'h1);
    commit();
    set_iss(9); set_wr(1, 9, 32'h00000099);
    sample();
    check("x9 reissue with wb stall", 32'(iss_stall), 32'h0);
    commit();
    set_idle();
    sample();
    check("x9 busy after set-wins", 32'(rd_hazard[0]), 32'h1);
    check("x9 data after wb", rd_data[31:0], 32'h00000099);
    commit();

    // Randomized traffic over a narrow address range to force collisions.
    for (int n = 0; n < 400; n++) begin
      set_idle();
      for (int k = 0; k < NWR; k++)
        if ($urandom_range(0, 2) == 0) set_wr(k, $urandom_range(0, 11), $urandom);
      if ($urandom_range(0, 1) == 1) set_iss($urandom_range(0, 11));
      for (int i = 0; i < NRD; i++) begin
        if ($urandom_range(0, 3) == 0 && wr_en[0]) set_rd(i, int'(wr_addr[AW-1:0]));
        else set_rd(i, $urandom_range(0, 11));
      end
      sample();
      if ($urandom_range(0, 60) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check("random async reset rd0", rd_data[31:0], 32'h0);
        check("random async reset haz", 32'(rd_hazard), 32'h0);
        #1 rst_n = 1'b1;
        #1 check_outputs();
      end
      commit();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_reg_file_mp
